// File: rtl/if_id_queue.sv
// Elastic IF/ID boundary: a DEPTH-entry FIFO of {instruction, pc} beats between
// fetch and decode. Valid/ready on both sides, with a synchronous flush that
// squashes every buffered beat. An empty queue presents NOP to decode.
module if_id_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_instruction,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_instruction,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Storage is never reset: out_valid gates what decode sees.
  logic [DEPTH-1:0][XLEN-1:0] instr_mem;
  logic [DEPTH-1:0][XLEN-1:0] pc_mem;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic                       push;
  logic                       pop;

  // Handshakes and head view depend only on registered state. No pass-through
  // when full and no write-to-read bypass when empty.
  always_comb begin
    in_ready        = (count != CW'(DEPTH));
    out_valid       = (count != '0);
    push            = in_valid & in_ready;
    pop             = out_valid & out_ready;
    out_instruction = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
    out_pc          = out_valid ? pc_mem[rd_ptr]    : '0;
  end

  // Write the accepted beat into the tail slot; a flush-cycle push is dropped.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      instr_mem[wr_ptr] <= in_instruction;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  // Pointers and occupancy; flush wins over push/pop, pointers wrap modulo DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Randomized bench for if_id_queue. Stimulus only drives pins; a monitor on the
// falling edge holds the expected queue contents (an SV queue of beats),
// compares every visible output against it, then applies the cycle's
// handshakes to the expected queue.
module tb_if_id_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_instruction = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_instruction;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      count;

  if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    errors  = 0;
  int    popped  = 0;
  int    max_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare outputs with the expected queue, then apply this cycle's
  // handshakes (flush discards everything, full refuses push, empty refuses pop).
  always @(negedge clock) begin
    int  sz;
    bit  do_push;
    bit  do_pop;
    if (reset) exp_q.delete();
    sz = exp_q.size();
    check("count",     32'(count),     32'(sz));
    check("out_valid", 32'(out_valid), 32'(sz != 0));
    check("in_ready",  32'(in_ready),  32'(sz != DEPTH));
    check("out_instr", out_instruction, (sz != 0) ? exp_q[0].instr : NOP);
    check("out_pc",    out_pc,          (sz != 0) ? exp_q[0].pc    : 32'h0);
    if (32'(count) > max_cnt) max_cnt = 32'(count);
    if (!reset) begin
      do_push = in_valid && (sz != DEPTH);
      do_pop  = out_ready && (sz != 0);
      if (flush) exp_q.delete();
      else begin
        if (do_pop) begin
          void'(exp_q.pop_front());
          popped++;
        end
        if (do_push) exp_q.push_back('{instr: in_instruction, pc: in_pc});
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    @(posedge clock);
    #1;
    in_valid       = v;
    in_pc          = pc;
    in_instruction = $urandom;
    out_ready      = rdy;
    flush          = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset mid-stream with three beats buffered.
    for (int k = 0; k < 3; k++) drive(1'b1, 32'(k * 4), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instruction, NOP);
    check("rst_out_pc",    out_pc,          32'h0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clock);
    #1 reset = 1'b0;

    // Fill to DEPTH with decode stalled, offer a fifth beat, then drain.
    for (int k = 0; k < 5; k++) drive(1'b1, 32'(k * 4), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("full_count",    32'(count),    32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    idle(5);

    // Push and pop together at count=2.
    drive(1'b1, 32'h20, 1'b0, 1'b0);
    drive(1'b1, 32'h24, 1'b0, 1'b0);
    drive(1'b1, 32'h28, 1'b1, 1'b0);
    drive(1'b0, 32'h0,  1'b0, 1'b0);
    #1;
    check("simul_count", 32'(count), 32'd2);
    check("simul_head",  out_pc,     32'h24);
    idle(4);

    // Flush at count=3 while fetch offers pc 0x40 and decode pops.
    for (int k = 0; k < 3; k++) drive(1'b1, 32'(32'h30 + k * 4), 1'b0, 1'b0);
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    drive(1'b0, 32'h0,  1'b0, 1'b0);
    #1;
    check("flush_count", 32'(count),      32'd0);
    check("flush_instr", out_instruction, NOP);
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    idle(3);

    // Streaming at full rate wraps the pointers; occupancy stays at most 1.
    max_cnt = 0;
    for (int k = 0; k < 10; k++) drive(1'b1, 32'(32'h100 + k * 4), 1'b1, 1'b0);
    idle(3);
    check("wrap_max_count", 32'(max_cnt), 32'd1);

    // Random traffic with random backpressure and occasional flushes.
    for (int k = 0; k < 1000; k++) begin
      bit v, r, f;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 60) == 0);
      drive(v, 32'(32'h1000 + k * 4), r, f);
    end
    idle(DEPTH + 2);
    check("drained_count", 32'(count), 32'd0);

    @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
